// File: rtl/serial_bit_feeder.sv
// ============================================================================
//  Module   : serial_bit_feeder
//  Purpose  : Parallel-to-serial front end for the two-flip-flop serial
//             sequence detector. A word accepted over a valid/ready handshake
//             is presented one bit at a time on x. Each bit is consumed on a
//             clk edge where bit_en=1.
//  Options  : `define PARITY_EN appends the even parity of the word (^in_data)
//             as one extra bit after the data bits.
//  Ports    : clk       - rising-edge clock
//             reset     - asynchronous, active-low reset
//             bit_en    - consume the current bit on this edge
//             in_valid  - in_data carries a word
//             in_data   - parallel word to serialize (WIDTH bits)
//             in_ready  - block can accept a word (registered)
//             x         - serial bit, 0 when x_valid=0 (registered)
//             x_valid   - x carries a live bit (registered)
//             bit_cnt   - bits left in the word, current bit included
//             done      - one-cycle pulse after the final bit is consumed
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          bit_en,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          in_ready,
  output logic                          x,
  output logic                          x_valid,
  output logic [$clog2(WIDTH+2)-1:0]    bit_cnt,
  output logic                          done
);

  localparam int c_CNT_W = $clog2(WIDTH + 2);
`ifdef PARITY_EN
  localparam int c_BITS  = WIDTH + 1;
`else
  localparam int c_BITS  = WIDTH;
`endif
  localparam logic [c_CNT_W-1:0] c_LOAD = c_CNT_W'(c_BITS);
  localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);
`ifdef PARITY_EN
  // With parity the last data bit is the one seen while two bits remain.
  localparam logic [c_CNT_W-1:0] c_TWO  = c_CNT_W'(2);
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1
`ifdef PARITY_EN
    , S_PAR = 2'd2
`endif
  } state_t;

  state_t               r_state,    w_state_nxt;
  logic [WIDTH-1:0]     r_shreg,    w_shreg_nxt;
  logic [c_CNT_W-1:0]   r_cnt,      w_cnt_nxt;
  logic                 r_in_ready, w_in_ready_nxt;
  logic                 r_x,        w_x_nxt;
  logic                 r_x_valid,  w_x_valid_nxt;
  logic                 r_done,     w_done_nxt;
`ifdef PARITY_EN
  logic                 r_par,      w_par_nxt;
`endif
  logic [WIDTH-1:0]     w_shifted;

  // Rotate rather than zero-fill: the wrapped-around bit is never presented
  // because bit_cnt ends the word before it reaches the output position.
  assign w_shifted = MSB_FIRST ? {r_shreg[WIDTH-2:0], r_shreg[WIDTH-1]}
                               : {r_shreg[0], r_shreg[WIDTH-1:1]};

  function automatic logic out_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  always_comb begin
    w_state_nxt    = r_state;
    w_shreg_nxt    = r_shreg;
    w_cnt_nxt      = r_cnt;
    w_in_ready_nxt = r_in_ready;
    w_x_nxt        = r_x;
    w_x_valid_nxt  = r_x_valid;
    w_done_nxt     = 1'b0;
`ifdef PARITY_EN
    w_par_nxt      = r_par;
`endif
    case (r_state)
      S_IDLE: begin
        w_in_ready_nxt = 1'b1;
        w_x_nxt        = 1'b0;
        w_x_valid_nxt  = 1'b0;
        w_cnt_nxt      = '0;
        if (in_valid && r_in_ready) begin
          w_shreg_nxt    = in_data;
          w_cnt_nxt      = c_LOAD;
          w_in_ready_nxt = 1'b0;
          w_x_valid_nxt  = 1'b1;
          w_x_nxt        = out_bit(in_data);
          w_state_nxt    = S_SHIFT;
`ifdef PARITY_EN
          w_par_nxt      = ^in_data;
`endif
        end
      end
      S_SHIFT: begin
        if (bit_en) begin
          w_shreg_nxt = w_shifted;
          w_cnt_nxt   = r_cnt - c_ONE;
          w_x_nxt     = out_bit(w_shifted);
`ifdef PARITY_EN
          if (r_cnt == c_TWO) begin
            w_state_nxt = S_PAR;
            w_x_nxt     = r_par;
          end
`else
          if (r_cnt == c_ONE) begin
            w_state_nxt    = S_IDLE;
            w_x_nxt        = 1'b0;
            w_x_valid_nxt  = 1'b0;
            w_cnt_nxt      = '0;
            w_done_nxt     = 1'b1;
            w_in_ready_nxt = 1'b1;
          end
`endif
        end
      end
`ifdef PARITY_EN
      S_PAR: begin
        if (bit_en) begin
          w_state_nxt    = S_IDLE;
          w_x_nxt        = 1'b0;
          w_x_valid_nxt  = 1'b0;
          w_cnt_nxt      = '0;
          w_done_nxt     = 1'b1;
          w_in_ready_nxt = 1'b1;
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_shreg    <= '0;
      r_cnt      <= '0;
      r_in_ready <= 1'b0;
      r_x        <= 1'b0;
      r_x_valid  <= 1'b0;
      r_done     <= 1'b0;
`ifdef PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_shreg    <= w_shreg_nxt;
      r_cnt      <= w_cnt_nxt;
      r_in_ready <= w_in_ready_nxt;
      r_x        <= w_x_nxt;
      r_x_valid  <= w_x_valid_nxt;
      r_done     <= w_done_nxt;
`ifdef PARITY_EN
      r_par      <= w_par_nxt;
`endif
    end
  end

  assign in_ready = r_in_ready;
  assign x        = r_x;
  assign x_valid  = r_x_valid;
  assign bit_cnt  = r_cnt;
  assign done     = r_done;

endmodule

`default_nettype wire
